// File: rtl/checkpoint_map_table_pkg.sv
// Shared constants and types for the checkpointed rename map table.
package checkpoint_map_table_pkg;
   localparam int NUM_ARCH_REGS = 32;
   localparam int ARCH_ADDR_W   = 5;

   // Pointer type sized for the default checkpoint depth of four slots.
   localparam int DEFAULT_NUM_CKPT = 4;
   localparam int CKPT_PTR_W       = $clog2(DEFAULT_NUM_CKPT);
   typedef logic [CKPT_PTR_W-1:0] ckpt_ptr_t;

   typedef logic [ARCH_ADDR_W-1:0] arch_addr_t;
endpackage

// File: rtl/map_snapshot_slot.sv
// One checkpoint copy of the rename map: bulk load plus tag-matched commit clear.
module map_snapshot_slot
   import checkpoint_map_table_pkg::*;
#(
   parameter int TAG_W = 6
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 load_i,
   input  logic [NUM_ARCH_REGS-1:0][TAG_W-1:0]  load_tbl_i,
   input  logic                                 clr_en_i,
   input  arch_addr_t                           clr_addr_i,
   input  logic [TAG_W-1:0]                     clr_tag_i,
   output logic [NUM_ARCH_REGS-1:0][TAG_W-1:0]  tbl_o
);
   logic [NUM_ARCH_REGS-1:0][TAG_W-1:0] tbl;

   // A load already carries this cycle's commit clear, so it takes precedence.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tbl <= '0;
      end else if (load_i) begin
         tbl <= load_tbl_i;
      end else if (clr_en_i && clr_addr_i != '0 && tbl[clr_addr_i] == clr_tag_i) begin
         tbl[clr_addr_i] <= '0;
      end
   end

   assign tbl_o = tbl;
endmodule

// File: rtl/checkpoint_map_table.sv
// Register rename map with a circular queue of branch checkpoints for fast mispredict recovery.
module checkpoint_map_table
   import checkpoint_map_table_pkg::*;
#(
   parameter int ROB_SIZE = 32,
   parameter int TAG_W    = $clog2(ROB_SIZE + 1),
   parameter int NUM_CKPT = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  arch_addr_t                    rd_addr1_i,
   input  arch_addr_t                    rd_addr2_i,
   output logic [TAG_W-1:0]              rd_tag1_o,
   output logic [TAG_W-1:0]              rd_tag2_o,
   input  logic                          wr_en_i,
   input  arch_addr_t                    wr_addr_i,
   input  logic [TAG_W-1:0]              wr_tag_i,
   input  logic                          commit_en_i,
   input  arch_addr_t                    commit_addr_i,
   input  logic [TAG_W-1:0]              commit_tag_i,
   input  logic                          ckpt_take_i,
   output logic [$clog2(NUM_CKPT)-1:0]   ckpt_id_o,
   output logic                          ckpt_full_o,
   output logic [$clog2(NUM_CKPT):0]     ckpt_count_o,
   input  logic                          ckpt_release_i,
   input  logic                          restore_i,
   input  logic [$clog2(NUM_CKPT)-1:0]   restore_id_i
);
   localparam int PTR_W = $clog2(NUM_CKPT);
   localparam int CNT_W = PTR_W + 1;

   typedef logic [NUM_ARCH_REGS-1:0][TAG_W-1:0] table_t;

   table_t live, live_clr, take_tbl, restore_tbl, live_next;
   table_t snap [NUM_CKPT];

   logic [PTR_W-1:0]    head, tail, head_next, tail_next, rst_ofs;
   logic [CNT_W-1:0]    count, count_next;
   logic [NUM_CKPT-1:0] slot_valid, slot_load;
   logic                restore_ok, take_ok, rel_ok, full;

   function automatic logic [CNT_W-1:0] age(input logic [PTR_W-1:0] slot,
                                            input logic [PTR_W-1:0] base);
      logic [PTR_W-1:0] d;
      d = slot - base;
      return {1'b0, d};
   endfunction

   assign full         = (count == CNT_W'(NUM_CKPT));
   assign ckpt_full_o  = full;
   assign ckpt_count_o = count;
   assign ckpt_id_o    = tail;
   assign rd_tag1_o    = (rd_addr1_i == '0) ? '0 : live[rd_addr1_i];
   assign rd_tag2_o    = (rd_addr2_i == '0) ? '0 : live[rd_addr2_i];

   // Next-state tables: commit clear first, then the rename write overrides it.
   always_comb begin
      live_clr = live;
      if (commit_en_i && commit_addr_i != '0 && live[commit_addr_i] == commit_tag_i)
         live_clr[commit_addr_i] = '0;
      take_tbl = live_clr;
      if (wr_en_i && wr_addr_i != '0)
         take_tbl[wr_addr_i] = wr_tag_i;
      restore_tbl = snap[restore_id_i];
      if (commit_en_i && commit_addr_i != '0 && restore_tbl[commit_addr_i] == commit_tag_i)
         restore_tbl[commit_addr_i] = '0;
      live_next = restore_ok ? restore_tbl : take_tbl;
   end

   always_comb begin
      for (int i = 0; i < NUM_CKPT; i++)
         slot_valid[i] = age(PTR_W'(i), head) < count;
      rst_ofs    = restore_id_i - head;
      restore_ok = restore_i && ({1'b0, rst_ofs} < count);
      rel_ok     = ckpt_release_i && (count != '0);
      take_ok    = ckpt_take_i && (!full || ckpt_release_i);
      head_next  = head;
      tail_next  = tail;
      count_next = count;
      slot_load  = '0;
      if (restore_ok) begin
         // Restored slot and everything younger become free again.
         tail_next = restore_id_i;
         if (ckpt_release_i && rst_ofs != '0) begin
            head_next  = head + PTR_W'(1);
            count_next = {1'b0, rst_ofs} - CNT_W'(1);
         end else begin
            count_next = {1'b0, rst_ofs};
         end
      end else begin
         if (take_ok) begin
            slot_load[tail] = 1'b1;
            tail_next       = tail + PTR_W'(1);
         end
         if (rel_ok)
            head_next = head + PTR_W'(1);
         count_next = count + CNT_W'(take_ok) - CNT_W'(rel_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         live  <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         live  <= live_next;
         head  <= head_next;
         tail  <= tail_next;
         count <= count_next;
      end
   end

   for (genvar g = 0; g < NUM_CKPT; g++) begin : g_slot
      map_snapshot_slot #(.TAG_W(TAG_W)) u_slot (
         .clk        (clk),
         .reset      (reset),
         .load_i     (slot_load[g]),
         .load_tbl_i (take_tbl),
         .clr_en_i   (commit_en_i && slot_valid[g]),
         .clr_addr_i (commit_addr_i),
         .clr_tag_i  (commit_tag_i),
         .tbl_o      (snap[g])
      );
   end
endmodule

// File: tb/tb_checkpoint_map_table.sv
// Directed vector bench for checkpoint_map_table with default parameters.
module tb_checkpoint_map_table;
   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rd_addr1_i, rd_addr2_i, wr_addr_i, commit_addr_i;
   logic [5:0] rd_tag1_o, rd_tag2_o, wr_tag_i, commit_tag_i;
   logic       wr_en_i, commit_en_i, ckpt_take_i, ckpt_full_o, ckpt_release_i, restore_i;
   logic [1:0] ckpt_id_o, restore_id_i;
   logic [2:0] ckpt_count_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   checkpoint_map_table dut (
      .clk(clk), .reset(reset),
      .rd_addr1_i(rd_addr1_i), .rd_addr2_i(rd_addr2_i),
      .rd_tag1_o(rd_tag1_o), .rd_tag2_o(rd_tag2_o),
      .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_tag_i(wr_tag_i),
      .commit_en_i(commit_en_i), .commit_addr_i(commit_addr_i), .commit_tag_i(commit_tag_i),
      .ckpt_take_i(ckpt_take_i), .ckpt_id_o(ckpt_id_o), .ckpt_full_o(ckpt_full_o),
      .ckpt_count_o(ckpt_count_o), .ckpt_release_i(ckpt_release_i),
      .restore_i(restore_i), .restore_id_i(restore_id_i)
   );

   typedef struct {
      logic       we;  logic [4:0] wa; logic [5:0] wt;
      logic       ce;  logic [4:0] ca; logic [5:0] ct;
      logic       tk;  logic rl; logic rs; logic [1:0] rid;
      logic [4:0] r1;  logic [4:0] r2;
      logic [5:0] e1;  logic [5:0] e2;
      logic [1:0] eid; logic [2:0] ecnt; logic efull;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int we, wa, wt, ce, ca, ct, tk, rl, rs, rid,
                               r1, r2, e1, e2, eid, ecnt, efull);
      vec_t v;
      v.we = 1'(we);  v.wa = 5'(wa);  v.wt = 6'(wt);
      v.ce = 1'(ce);  v.ca = 5'(ca);  v.ct = 6'(ct);
      v.tk = 1'(tk);  v.rl = 1'(rl);  v.rs = 1'(rs); v.rid = 2'(rid);
      v.r1 = 5'(r1);  v.r2 = 5'(r2);
      v.e1 = 6'(e1);  v.e2 = 6'(e2);
      v.eid = 2'(eid); v.ecnt = 3'(ecnt); v.efull = 1'(efull);
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic idle_inputs();
      wr_en_i = 0; wr_addr_i = 0; wr_tag_i = 0;
      commit_en_i = 0; commit_addr_i = 0; commit_tag_i = 0;
      ckpt_take_i = 0; ckpt_release_i = 0; restore_i = 0; restore_id_i = 0;
   endtask

   task automatic check_outputs(input int idx, input int e1, e2, eid, ecnt, efull);
      chk("rd_tag1", idx, int'(rd_tag1_o), e1);
      chk("rd_tag2", idx, int'(rd_tag2_o), e2);
      chk("ckpt_id", idx, int'(ckpt_id_o), eid);
      chk("ckpt_count", idx, int'(ckpt_count_o), ecnt);
      chk("ckpt_full", idx, int'(ckpt_full_o), efull);
   endtask

   initial begin
      //          we wa wt ce ca ct tk rl rs rid r1 r2 | e1 e2 id cnt full
      vecs.push_back(mk(1, 3, 5, 0, 0, 0, 0, 0, 0, 0,  3, 7,  5, 0, 0, 0, 0));
      vecs.push_back(mk(1, 7, 9, 0, 0, 0, 0, 0, 0, 0,  3, 7,  5, 9, 0, 0, 0));
      vecs.push_back(mk(1, 0, 4, 0, 0, 0, 0, 0, 0, 0,  0, 3,  0, 5, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 3, 6, 0, 0, 0, 0,  3, 7,  5, 9, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 3, 5, 0, 0, 0, 0,  3, 7,  0, 9, 0, 0, 0));
      vecs.push_back(mk(1, 3, 5, 0, 0, 0, 0, 0, 0, 0,  3, 7,  5, 9, 0, 0, 0));
      vecs.push_back(mk(1, 3, 8, 1, 3, 5, 0, 0, 0, 0,  3, 7,  8, 9, 0, 0, 0));
      vecs.push_back(mk(1, 4, 2, 0, 0, 0, 0, 0, 0, 0,  4, 3,  2, 8, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  4, 3,  2, 8, 1, 1, 0));
      vecs.push_back(mk(1, 4, 11,0, 0, 0, 0, 0, 0, 0,  4, 3, 11, 8, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  4, 3, 11, 8, 2, 2, 0));
      vecs.push_back(mk(1, 4, 12,0, 0, 0, 0, 0, 0, 0,  4, 3, 12, 8, 2, 2, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  4, 3,  2, 8, 0, 0, 0));
      vecs.push_back(mk(1, 5, 3, 0, 0, 0, 0, 0, 0, 0,  5, 4,  3, 2, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  5, 4,  3, 2, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 5, 3, 0, 0, 0, 0,  5, 4,  0, 2, 1, 1, 0));
      vecs.push_back(mk(1, 5, 7, 0, 0, 0, 0, 0, 0, 0,  5, 4,  7, 2, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  5, 4,  0, 2, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  6, 4,  0, 2, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  6, 4,  0, 2, 2, 2, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  6, 4,  0, 2, 3, 3, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  6, 4,  0, 2, 0, 4, 1));
      vecs.push_back(mk(1, 6, 1, 0, 0, 0, 1, 0, 0, 0,  6, 4,  1, 2, 0, 4, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  6, 4,  1, 2, 1, 4, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  6, 4,  1, 2, 1, 3, 0));
      vecs.push_back(mk(1, 6, 2, 0, 0, 0, 0, 0, 1, 1,  6, 4,  2, 2, 1, 3, 0));
      vecs.push_back(mk(1, 4, 15,0, 0, 0, 1, 1, 1, 3,  6, 4,  0, 2, 3, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  6, 4,  0, 2, 3, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  6, 4,  0, 2, 0, 1, 0));
      vecs.push_back(mk(1, 9, 13,0, 0, 0, 1, 0, 0, 0,  9, 4, 13, 2, 1, 2, 0));
      vecs.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0,  9, 4,  1, 2, 1, 2, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  9, 4, 13, 2, 0, 1, 0));

      idle_inputs();
      rd_addr1_i = 3; rd_addr2_i = 7;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs(-1, 0, 0, 0, 0, 0);

      @(negedge clk);
      reset = 1'b1;
      foreach (vecs[i]) begin
         @(negedge clk);
         wr_en_i = vecs[i].we; wr_addr_i = vecs[i].wa; wr_tag_i = vecs[i].wt;
         commit_en_i = vecs[i].ce; commit_addr_i = vecs[i].ca; commit_tag_i = vecs[i].ct;
         ckpt_take_i = vecs[i].tk; ckpt_release_i = vecs[i].rl;
         restore_i = vecs[i].rs; restore_id_i = vecs[i].rid;
         rd_addr1_i = vecs[i].r1; rd_addr2_i = vecs[i].r2;
         @(posedge clk);
         #1;
         check_outputs(i, int'(vecs[i].e1), int'(vecs[i].e2), int'(vecs[i].eid),
                       int'(vecs[i].ecnt), int'(vecs[i].efull));
      end

      // Restore and reset asserted together: reset must win.
      @(negedge clk);
      idle_inputs();
      restore_i = 1'b1; restore_id_i = 2'd0;
      reset = 1'b0;
      rd_addr1_i = 9; rd_addr2_i = 4;
      @(posedge clk);
      #1;
      check_outputs(100, 0, 0, 0, 0, 0);

      // Snapshots must also be cleared: a take then restore yields zeros.
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      ckpt_take_i = 1'b1;
      @(posedge clk);
      #1;
      check_outputs(101, 0, 0, 1, 1, 0);
      @(negedge clk);
      idle_inputs();
      restore_i = 1'b1; restore_id_i = 2'd0;
      @(posedge clk);
      #1;
      check_outputs(102, 0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
